alu: RTL and testbench

ALU -- requirements
Module: alu

---
 rtl/alu.sv | 218 +++++++++++++++++++++
 tb/tb_alu.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Pipelined integer ALU / branch-resolution unit broadcasting onto the result bus.
// Define ALU_FAST_EN for a single-stage (latency 1) build; default is two stages (latency 2).
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        alu_en,
    input  logic [6:0]  alu_opcode,
    input  logic [2:0]  alu_funct3,
    input  logic        alu_funct7,
    input  logic [31:0] alu_imm,
    input  logic [31:0] alu_pc,
    input  logic [31:0] alu_val1,
    input  logic [31:0] alu_val2,
    input  logic [3:0]  alu_rob_pos,
    output logic        result,
    output logic [3:0]  result_rob_pos,
    output logic [31:0] result_val,
    output logic        result_jump,
    output logic [31:0] result_pc
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned ROB_W = 4;
    localparam int unsigned SH_W  = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        K_NONE,
        K_ALU,
        K_LUI,
        K_AUIPC,
        K_JAL,
        K_JALR,
        K_BRANCH
    } kind_t;

    typedef struct packed {
        logic [XLEN-1:0] val;
        logic            jump;
        logic [XLEN-1:0] npc;
    } res_t;

    // Datapath for one decoded op: rd value, taken flag and resolved next PC.
    function automatic res_t execute(
        input kind_t           kind,
        input logic [2:0]      f3,
        input logic            alt,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b,
        input logic [XLEN-1:0] imm,
        input logic [XLEN-1:0] pc
    );
        res_t            r;
        logic [XLEN-1:0] pc4;
        logic [XLEN-1:0] tgt;
        logic [SH_W-1:0] sh;
        logic            taken;
        pc4    = pc + XLEN'(4);
        tgt    = a + imm;
        sh     = b[SH_W-1:0];
        taken  = 1'b0;
        r.val  = '0;
        r.jump = 1'b0;
        r.npc  = pc4;
        case (kind)
            K_ALU: begin
                case (f3)
                    3'b000:  r.val = alt ? (a - b) : (a + b);
                    3'b001:  r.val = a << sh;
                    3'b010:  r.val = {(XLEN-1)'(0), $signed(a) < $signed(b)};
                    3'b011:  r.val = {(XLEN-1)'(0), a < b};
                    3'b100:  r.val = a ^ b;
                    3'b101:  r.val = alt ? XLEN'($signed(a) >>> sh) : (a >> sh);
                    3'b110:  r.val = a | b;
                    default: r.val = a & b;
                endcase
            end
            K_LUI:   r.val = imm;
            K_AUIPC: r.val = pc + imm;
            K_JAL: begin
                r.val  = pc4;
                r.jump = 1'b1;
                r.npc  = pc + imm;
            end
            K_JALR: begin
                r.val  = pc4;
                r.jump = 1'b1;
                r.npc  = {tgt[XLEN-1:1], 1'b0};
            end
            K_BRANCH: begin
                case (f3)
                    3'b000:  taken = (a == b);
                    3'b001:  taken = (a != b);
                    3'b100:  taken = ($signed(a) <  $signed(b));
                    3'b101:  taken = ($signed(a) >= $signed(b));
                    3'b110:  taken = (a <  b);
                    3'b111:  taken = (a >= b);
                    default: taken = 1'b0;
                endcase
                r.jump = taken;
                if (taken) begin
                    r.npc = pc + imm;
                end
            end
            default: ;
        endcase
        return r;
    endfunction

    kind_t           d_kind;
    logic            d_alt;
    logic [XLEN-1:0] d_op2;

    // Decode: op class, second operand, and SUB/SRA select.
    always_comb begin
        d_kind = K_NONE;
        d_op2  = alu_val2;
        d_alt  = 1'b0;
        case (alu_opcode)
            OPC_OP:     d_kind = K_ALU;
            OPC_OP_IMM: begin
                d_kind = K_ALU;
                d_op2  = alu_imm;
            end
            OPC_BRANCH: d_kind = K_BRANCH;
            OPC_LUI:    d_kind = K_LUI;
            OPC_AUIPC:  d_kind = K_AUIPC;
            OPC_JAL:    d_kind = K_JAL;
            OPC_JALR:   d_kind = K_JALR;
            default:    d_kind = K_NONE;
        endcase
        if (alu_funct3 == 3'b000) begin
            d_alt = (alu_opcode == OPC_OP) && alu_funct7;
        end else begin
            d_alt = alu_funct7;
        end
    end

    logic             x_valid;
    logic [ROB_W-1:0] x_rob;
    res_t             x_res;

`ifdef ALU_FAST_EN
    assign x_valid = alu_en;
    assign x_rob   = alu_rob_pos;
    assign x_res   = execute(d_kind, alu_funct3, d_alt, alu_val1, d_op2, alu_imm, alu_pc);
`else
    logic             e1_valid;
    logic [ROB_W-1:0] e1_rob;
    kind_t            e1_kind;
    logic [2:0]       e1_f3;
    logic             e1_alt;
    logic [XLEN-1:0]  e1_a;
    logic [XLEN-1:0]  e1_b;
    logic [XLEN-1:0]  e1_imm;
    logic [XLEN-1:0]  e1_pc;

    // E1: register decoded op and operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            e1_valid <= 1'b0;
            e1_rob   <= '0;
            e1_kind  <= K_NONE;
            e1_f3    <= '0;
            e1_alt   <= 1'b0;
            e1_a     <= '0;
            e1_b     <= '0;
            e1_imm   <= '0;
            e1_pc    <= '0;
        end else if (rdy) begin
            e1_valid <= alu_en && !rollback;
            if (alu_en) begin
                e1_rob  <= alu_rob_pos;
                e1_kind <= d_kind;
                e1_f3   <= alu_funct3;
                e1_alt  <= d_alt;
                e1_a    <= alu_val1;
                e1_b    <= d_op2;
                e1_imm  <= alu_imm;
                e1_pc   <= alu_pc;
            end
        end
    end

    assign x_valid = e1_valid;
    assign x_rob   = e1_rob;
    assign x_res   = execute(e1_kind, e1_f3, e1_alt, e1_a, e1_b, e1_imm, e1_pc);
`endif

    // Result stage: data held when idle; only the valid pulse is cleared.
    always_ff @(posedge clk) begin
        if (rst) begin
            result         <= 1'b0;
            result_rob_pos <= '0;
            result_val     <= '0;
            result_jump    <= 1'b0;
            result_pc      <= '0;
        end else if (rdy) begin
            result <= x_valid && !rollback;
            if (x_valid && !rollback) begin
                result_rob_pos <= x_rob;
                result_val     <= x_res.val;
                result_jump    <= x_res.jump;
                result_pc      <= x_res.npc;
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases plus random traffic against a reference model.
module tb_alu;

`ifdef ALU_FAST_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic        clk;
    logic        rst, rdy, rollback, alu_en;
    logic [6:0]  alu_opcode;
    logic [2:0]  alu_funct3;
    logic        alu_funct7;
    logic [31:0] alu_imm, alu_pc, alu_val1, alu_val2;
    logic [3:0]  alu_rob_pos;
    logic        result;
    logic [3:0]  result_rob_pos;
    logic [31:0] result_val;
    logic        result_jump;
    logic [31:0] result_pc;

    alu dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback), .alu_en(alu_en),
        .alu_opcode(alu_opcode), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
        .alu_imm(alu_imm), .alu_pc(alu_pc), .alu_val1(alu_val1), .alu_val2(alu_val2),
        .alu_rob_pos(alu_rob_pos), .result(result), .result_rob_pos(result_rob_pos),
        .result_val(result_val), .result_jump(result_jump), .result_pc(result_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  rob;
        logic [31:0] val;
        logic        jump;
        logic [31:0] pc;
        int          due;
    } exp_t;

    exp_t        q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          adv = 0;
    int          pulses = 0;
    logic        e_res = 1'b0;
    logic        e_full = 1'b0;
    logic [3:0]  e_rob = '0;
    logic [31:0] e_val = '0, e_pc = '0;
    logic        e_jump = 1'b0;
    logic [3:0]  got_rob;
    logic [31:0] got_val, got_pc;
    logic        got_jump;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Architectural behaviour of one op, straight from the ISA rules.
    function automatic void ref_exec(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                                     input logic [31:0] imm, input logic [31:0] pc,
                                     input logic [31:0] v1, input logic [31:0] v2,
                                     output logic [31:0] val, output logic jump,
                                     output logic [31:0] npc);
        logic [31:0] op2;
        int          sh;
        longint      sa, sb, ua, ub;
        val  = 0;
        jump = 0;
        npc  = pc + 4;
        op2  = (opc == 7'h13) ? imm : v2;
        sh   = int'(op2 % 32);
        sa   = longint'($signed(v1));
        sb   = longint'($signed(op2));
        ua   = longint'({32'd0, v1});
        ub   = longint'({32'd0, op2});
        if (opc == 7'h33 || opc == 7'h13) begin
            case (f3)
                0: val = (opc == 7'h33 && f7) ? 32'(ua - ub) : 32'(ua + ub);
                1: val = 32'(ua << sh);
                2: val = (sa < sb) ? 1 : 0;
                3: val = (ua < ub) ? 1 : 0;
                4: val = v1 ^ op2;
                5: val = f7 ? 32'(sa >>> sh) : 32'(ua >> sh);
                6: val = v1 | op2;
                7: val = v1 & op2;
            endcase
        end else if (opc == 7'h37) begin
            val = imm;
        end else if (opc == 7'h17) begin
            val = pc + imm;
        end else if (opc == 7'h6F) begin
            val = pc + 4; jump = 1; npc = pc + imm;
        end else if (opc == 7'h67) begin
            val = pc + 4; jump = 1; npc = (v1 + imm) & 32'hFFFF_FFFE;
        end else if (opc == 7'h63) begin
            case (f3)
                0: jump = (ua == ub);
                1: jump = (ua != ub);
                4: jump = (sa < sb);
                5: jump = (sa >= sb);
                6: jump = (ua < ub);
                7: jump = (ua >= ub);
                default: jump = 0;
            endcase
            if (jump) npc = pc + imm;
        end
    endfunction

    // One clock: drive at negedge, then update the model and check after the edge.
    task automatic cycle(input logic r, input logic y, input logic rb, input logic en,
                         input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                         input logic [31:0] imm, input logic [31:0] pc,
                         input logic [31:0] v1, input logic [31:0] v2, input logic [3:0] rob);
        exp_t e;
        @(negedge clk);
        rst = r; rdy = y; rollback = rb; alu_en = en;
        alu_opcode = opc; alu_funct3 = f3; alu_funct7 = f7;
        alu_imm = imm; alu_pc = pc; alu_val1 = v1; alu_val2 = v2; alu_rob_pos = rob;
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
            e_res = 0; e_full = 1; e_rob = 0; e_val = 0; e_jump = 0; e_pc = 0;
        end else if (y) begin
            adv++;
            if (rb) begin
                q.delete();
                e_res = 0; e_full = 0;
            end else begin
                if (en) begin
                    e.rob = rob;
                    e.due = adv + LAT - 1;
                    ref_exec(opc, f3, f7, imm, pc, v1, v2, e.val, e.jump, e.pc);
                    q.push_back(e);
                end
                if (q.size() > 0 && q[0].due == adv) begin
                    e_res = 1; e_full = 1;
                    e_rob = q[0].rob; e_val = q[0].val; e_jump = q[0].jump; e_pc = q[0].pc;
                    void'(q.pop_front());
                end else begin
                    e_res = 0; e_full = 0;
                end
            end
        end
        check("result", 32'(result), 32'(e_res));
        if (e_full) begin
            check("rob_pos", 32'(result_rob_pos), 32'(e_rob));
            check("val", result_val, e_val);
            check("jump", 32'(result_jump), 32'(e_jump));
            check("pc", result_pc, e_pc);
        end
        if (result) begin
            pulses++;
            got_rob = result_rob_pos; got_val = result_val;
            got_jump = result_jump; got_pc = result_pc;
        end
    endtask

    task automatic idle();
        cycle(0, 1, 0, 0, 7'h00, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
    endtask

    task automatic op(input logic [6:0] opc, input logic [2:0] f3, input logic f7,
                      input logic [31:0] imm, input logic [31:0] pc,
                      input logic [31:0] v1, input logic [31:0] v2, input logic [3:0] rob);
        cycle(0, 1, 0, 1, opc, f3, f7, imm, pc, v1, v2, rob);
    endtask

    // Issue one op alone and compare the broadcast against fixed expected values.
    task automatic run_op(input string tag, input logic [6:0] opc, input logic [2:0] f3,
                          input logic f7, input logic [31:0] imm, input logic [31:0] pc,
                          input logic [31:0] v1, input logic [31:0] v2, input logic [3:0] rob,
                          input logic [31:0] xval, input logic xjump, input logic [31:0] xpc);
        int p0, n;
        p0 = pulses;
        op(opc, f3, f7, imm, pc, v1, v2, rob);
        n = 1;
        while (pulses == p0 && n < 6) begin
            idle();
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'(LAT));
        check({tag, "_rob"}, 32'(got_rob), 32'(rob));
        check({tag, "_val"}, got_val, xval);
        check({tag, "_jump"}, 32'(got_jump), 32'(xjump));
        check({tag, "_pc"}, got_pc, xpc);
        idle();
        idle();
    endtask

    logic [6:0] opcs [0:8];

    initial begin
        int p, n;
        opcs[0] = 7'h33; opcs[1] = 7'h13; opcs[2] = 7'h63; opcs[3] = 7'h37; opcs[4] = 7'h17;
        opcs[5] = 7'h6F; opcs[6] = 7'h67; opcs[7] = 7'h00; opcs[8] = 7'h03;

        // Reset: all outputs zero
        cycle(1, 1, 0, 0, 7'h00, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        cycle(1, 0, 1, 1, 7'h33, 3'd0, 1'b0, 32'd1, 32'd2, 32'd3, 32'd4, 4'd5);
        idle();

        run_op("sub",   7'h33, 3'd0, 1'b1, 32'd0,   32'h40,  32'd5,        32'd7,        4'd3, 32'hFFFF_FFFE, 1'b0, 32'h44);
        run_op("srai",  7'h13, 3'd5, 1'b1, 32'd4,   32'h40,  32'h8000_0000, 32'd0,       4'd4, 32'hF800_0000, 1'b0, 32'h44);
        run_op("addi",  7'h13, 3'd0, 1'b1, 32'd3,   32'h40,  32'd10,       32'd99,       4'd5, 32'd13,        1'b0, 32'h44);
        run_op("sllsh", 7'h33, 3'd1, 1'b0, 32'd0,   32'h40,  32'd3,        32'h21,       4'd6, 32'd6,         1'b0, 32'h44);
        run_op("slt",   7'h33, 3'd2, 1'b0, 32'd0,   32'h40,  32'hFFFF_FFFF, 32'd1,       4'd7, 32'd1,         1'b0, 32'h44);
        run_op("bltu",  7'h63, 3'd6, 1'b0, 32'h20,  32'h100, 32'd1,        32'hFFFF_FFFF, 4'd8, 32'd0,        1'b1, 32'h120);
        run_op("bge",   7'h63, 3'd5, 1'b0, 32'h20,  32'h100, 32'd1,        32'hFFFF_FFFF, 4'd9, 32'd0,        1'b1, 32'h120);
        run_op("blt",   7'h63, 3'd4, 1'b0, 32'h20,  32'h100, 32'd1,        32'hFFFF_FFFF, 4'd10, 32'd0,       1'b0, 32'h104);
        run_op("jalr",  7'h67, 3'd0, 1'b0, 32'd2,   32'h200, 32'h1001,     32'd0,        4'd11, 32'h204,      1'b1, 32'h1002);
        run_op("jal",   7'h6F, 3'd0, 1'b0, 32'h800, 32'h300, 32'd0,        32'd0,        4'd12, 32'h304,      1'b1, 32'hB00);
        run_op("lui",   7'h37, 3'd0, 1'b0, 32'h12345000, 32'h300, 32'd0,   32'd0,        4'd13, 32'h12345000, 1'b0, 32'h304);
        run_op("auipc", 7'h17, 3'd0, 1'b0, 32'h1000, 32'hFFFF_F000, 32'd0,  32'd0,        4'd14, 32'h0,        1'b0, 32'hFFFF_F004);
        run_op("unk",   7'h7F, 3'd0, 1'b0, 32'd7,   32'h40,  32'd1,        32'd1,        4'd15, 32'd0,        1'b0, 32'h44);

        // Back-to-back ops produce three pulses in order
        p = pulses;
        op(7'h33, 3'd0, 1'b0, 32'd0, 32'h10, 32'd1, 32'd1, 4'd1);
        op(7'h33, 3'd0, 1'b0, 32'd0, 32'h14, 32'd2, 32'd2, 4'd2);
        op(7'h33, 3'd0, 1'b0, 32'd0, 32'h18, 32'd3, 32'd3, 4'd3);
        repeat (4) idle();
        check("b2b_pulses", 32'(pulses - p), 32'd3);

        // Rollback in the second cycle flushes everything in flight
        op(7'h33, 3'd0, 1'b0, 32'd0, 32'h10, 32'd1, 32'd1, 4'd1);
        cycle(0, 1, 1, 1, 7'h33, 3'd0, 1'b0, 32'd0, 32'h14, 32'd2, 32'd2, 4'd2);
        p = pulses;
        repeat (4) idle();
        check("rb_pulses", 32'(pulses - p), 32'd0);

        // Two stalled cycles delay the broadcast by exactly two cycles
        p = pulses;
        op(7'h13, 3'd4, 1'b0, 32'hF0, 32'h20, 32'h0F, 32'd0, 4'd9);
        n = 1;
        if (LAT > 1) begin
            cycle(0, 0, 0, 0, 7'h00, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
            cycle(0, 0, 0, 0, 7'h00, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
            n = 3;
        end
        while (pulses == p && n < 8) begin
            idle();
            n++;
        end
        check("stall_lat", 32'(n), 32'(LAT + ((LAT > 1) ? 2 : 0)));
        check("stall_val", got_val, 32'hFF);
        // Stall while the result is being broadcast: result held high
        op(7'h13, 3'd6, 1'b0, 32'h1, 32'h20, 32'h2, 32'd0, 4'd4);
        cycle(0, 0, 0, 0, 7'h00, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        cycle(0, 0, 1, 0, 7'h00, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        repeat (3) idle();

        // Reset mid-flight: no broadcast
        op(7'h33, 3'd0, 1'b0, 32'd0, 32'h10, 32'd1, 32'd1, 4'd7);
        cycle(1, 1, 0, 0, 7'h00, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);
        p = pulses;
        repeat (4) idle();
        check("rst_pulses", 32'(pulses - p), 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [6:0] opc;
            opc = ($urandom_range(0, 19) == 0) ? 7'($urandom) : opcs[$urandom_range(0, 8)];
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 85),
                  ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 70),
                  opc, 3'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
                  ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
                  4'($urandom));
        end
        repeat (4) idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
